mac_seq: RTL and testbench
==========================

# mac_seq

Sequencer that drives one combinational `mac` datapath to compute a full dot product plus bias: out = bias + Σ in[k]·w[k], for k = 0..len-1. It accepts a job on a start strobe and streams operand pairs in over a valid/ready handshake. It accumulates one pair per cycle through the `mac` instance and presents the result on a valid/ready output port. It sits between the operand-fetch logic and the activation/writeback stage of a neuron lane.

## Interface
- `IP`, 8: input operand MSB index; input width is IP+1.
- `WP`, 8: weight operand MSB index; weight width is WP+1.
- `CP`, IP+WP: accumulator/bias/result MSB index; width is CP+1.
- `NMAX`, 64: maximum terms per job.
- `LW`, $clog2(NMAX+1): width of the `len` field.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LW: term count, 0..NMAX; sampled with `start`.
- `bias` in CP+1 signed: accumulator seed; sampled with `start`.
- `busy` out 1: high in any state other than IDLE.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: the sequencer accepts the pair this cycle.
- `in_data` in IP+1 signed: input activation.
- `w_data` in WP+1 signed: weight.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out CP+1 signed: result.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset puts it in IDLE, with acc=0, cnt=0, busy=0, in_ready=0, out_valid=0 and out_data=0.
- IDLE, when `start`=1: acc←bias and cnt←len. If len=0 the next state is DONE; otherwise it is RUN.
- RUN: in_ready=1. On in_valid&&in_ready: acc←mac(in_data, w_data, acc) and cnt←cnt-1. If cnt was 1, the next state is DONE. With in_valid=0, all state holds.
- DONE: out_valid=1 and out_data=acc (after the optional ReLU). On out_ready, the next state is IDLE.
- `start` is ignored outside IDLE. in_ready=0 outside RUN.
- A len greater than NMAX is clamped to NMAX.
- Arithmetic:
  - The product is truncated to CP+1 bits, two's complement, so -256·-256 wraps to -65536.
  - The sum wraps modulo 2^(CP+1).
  - There is no saturation.
- Reset mid-job aborts immediately to reset values. A partial result is never emitted.

## Timing
- Registered outputs: busy, in_ready, out_valid and out_data. None has a combinational path from any input.
- Start accepted at edge 0 with len=L≥1 and in_valid held high:
  - in_ready is high for cycles 1..L.
  - out_valid rises at cycle L+1.
- Start with len=0: out_valid rises at cycle 1.
- Throughput: one term per cycle, plus two cycles of overhead per job when out_ready is held high.
- out_data is stable while out_valid=1 and out_ready=0.
- The next start is accepted no earlier than the cycle after the output handshake.

## Configuration
- `MAC_SEQ_RELU_EN` defined: out_data = (acc<0) ? 0 : acc. ReLU is applied only at the output; acc itself is unchanged.
- `MAC_SEQ_RELU_EN` undefined: out_data = acc, the raw two's-complement result.

## Structure
- Shared package `mac_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constants IP, WP and CP.
- One sub-module: the existing combinational `mac` (in, w, b→out), instantiated once. Its `b` input is fed from `acc` and its `out` drives the `acc` next-value.
- Counter, FSM and output register live in `mac_seq`.

## Test plan
- Basic dot product: bias=10, len=3, pairs (2,3), (-4,5), (7,-1) → out_data=-11 at cycle 4. Expect 0 with MAC_SEQ_RELU_EN.
- Wrap boundary: bias=0, len=1, pair (-256,-256) → out_data=-65536 (17'h10000). With bias=65535, pair (1,1) → -65536.
- Zero length: bias=-5, len=0 → out_valid at cycle 1, out_data=-5 (0 with ReLU). in_ready never asserts.
- Backpressure:
  - Toggle in_valid 1-0-1-0 for len=4 → four accepts, correct sum.
  - Hold out_ready=0 for 5 cycles → out_data stable, start pulses ignored, busy=1.
- Reset mid-RUN: assert rst_n=0 after 2 of 5 terms → all outputs return to 0 asynchronously. A fresh job with bias=1, len=1, pair (3,3) → out_data=10.
- Clamp: len=NMAX+1 → exactly NMAX pairs accepted, then out_valid.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the mac_seq dot-product sequencer.
package mac_seq_pkg;

    localparam int IP = 8;
    localparam int WP = 8;
    localparam int CP = IP + WP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_seq_mac.sv
// Combinational multiply-accumulate: out = b + in*w, with the product
// truncated (or sign-extended) to the accumulator width.
module mac
    import mac_seq_pkg::*;
#(
    parameter int IP = mac_seq_pkg::IP,
    parameter int WP = mac_seq_pkg::WP,
    parameter int CP = mac_seq_pkg::CP
) (
    input  logic signed [IP:0] in,
    input  logic signed [WP:0] w,
    input  logic signed [CP:0] b,
    output logic signed [CP:0] out
);

    logic signed [IP+WP+1:0] prod;
    logic signed [CP:0]      prod_t;

    always_comb begin
        prod   = in * w;
        prod_t = (CP+1)'(prod);
        out    = b + prod_t;
    end

endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer: out = bias + sum(in[k]*w[k]) over len terms.
// Optional output ReLU enabled by defining MAC_SEQ_RELU_EN.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int IP   = mac_seq_pkg::IP,
    parameter int WP   = mac_seq_pkg::WP,
    parameter int CP   = mac_seq_pkg::CP,
    parameter int NMAX = 64,
    parameter int LW   = $clog2(NMAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic signed [CP:0]   bias,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IP:0]   in_data,
    input  logic signed [WP:0]   w_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CP:0]   out_data
);

    state_t               state_q, state_d;
    logic signed [CP:0]   acc_q, acc_d;
    logic [LW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        len_c;
    logic signed [CP:0]   mac_out;
    logic signed [CP:0]   out_d;

    function automatic logic signed [CP:0] shape(input logic signed [CP:0] v);
`ifdef MAC_SEQ_RELU_EN
        return v[CP] ? '0 : v;
`else
        return v;
`endif
    endfunction

    mac #(
        .IP(IP),
        .WP(WP),
        .CP(CP)
    ) u_mac (
        .in  (in_data),
        .w   (w_data),
        .b   (acc_q),
        .out (mac_out)
    );

    always_comb begin
        len_c = (len > LW'(NMAX)) ? LW'(NMAX) : len;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_data;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    cnt_d   = len_c;
                    state_d = (len_c == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid && in_ready) begin
                    acc_d = mac_out;
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Result is captured once on DONE entry so it stays put under backpressure.
        if (state_d == DONE && state_q != DONE) out_d = shape(acc_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy      <= (state_d != IDLE);
            in_ready  <= (state_d == RUN);
            out_valid <= (state_d == DONE);
            out_data  <= out_d;
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: directed vector table, multi-cycle corner
// sequences and randomized jobs against an arithmetic reference model.
module tb_mac_seq;

    localparam int IP     = 8;
    localparam int WP     = 8;
    localparam int CP     = 16;
    localparam int NMAX   = 64;
    localparam int LW     = $clog2(NMAX + 1);
    localparam int BUDGET = 300;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [LW-1:0]        len = '0;
    logic signed [CP:0]   bias = '0;
    logic                 busy;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [IP:0]   in_data = '0;
    logic signed [WP:0]   w_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [CP:0]   out_data;

    int errors = 0;
    int checks = 0;
    int pa[80];
    int pb[80];

    typedef struct {
        int bias;
        int len;
        int a[4];
        int b[4];
        bit toggle;
        int hold;
        int exp;
    } vec_t;

    vec_t tab[5];

    always #5 clk = ~clk;

    mac_seq #(
        .IP(IP),
        .WP(WP),
        .CP(CP),
        .NMAX(NMAX),
        .LW(LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic int relu_m(input int v);
`ifdef MAC_SEQ_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference: full-precision dot product, then reduce modulo 2^(CP+1).
    function automatic int model(input int b, input int n);
        longint s;
        logic signed [CP:0] t;
        s = longint'(b);
        for (int k = 0; k < n; k++) s += longint'(pa[k]) * longint'(pb[k]);
        t = s[CP:0];
        return int'(t);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int bias_i, input int len_i, input bit toggle,
                           input int hold, input int abort_at, input int exp_i,
                           input string tag);
        int le;
        int idx;
        int irc;
        int lat;
        le  = (len_i > NMAX) ? NMAX : len_i;
        idx = 0;
        irc = 0;
        lat = 0;
        @(negedge clk);
        bias     = (CP+1)'(bias_i);
        len      = LW'(len_i);
        start    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_at >= 0 && idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " rst busy"}, int'(busy), 0);
                chk({tag, " rst in_ready"}, int'(in_ready), 0);
                chk({tag, " rst out_valid"}, int'(out_valid), 0);
                chk({tag, " rst out_data"}, int'(out_data), 0);
                in_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (out_valid) begin
                lat = n;
                break;
            end
            if (in_ready) irc++;
            in_valid = toggle ? n[0] : 1'b1;
            in_data  = (IP+1)'(pa[idx]);
            w_data   = (WP+1)'(pb[idx]);
            if (in_ready && in_valid) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL %s timeout: out_valid not seen within %0d cycles", tag, BUDGET);
            return;
        end
        chk({tag, " out_data"}, int'(out_data), relu_m(exp_i));
        chk({tag, " accepts"}, idx, le);
        if (!toggle) chk({tag, " latency"}, lat, le + 1);
        if (le == 0) chk({tag, " in_ready cycles"}, irc, 0);
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            chk({tag, " hold out_data"}, int'(out_data), relu_m(exp_i));
            chk({tag, " hold out_valid"}, int'(out_valid), 1);
            chk({tag, " hold busy"}, int'(busy), 1);
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " post out_valid"}, int'(out_valid), 0);
        chk({tag, " post busy"}, int'(busy), 0);
    endtask

    initial begin
        tab[0] = '{bias: 10, len: 3, a: '{2, -4, 7, 0}, b: '{3, 5, -1, 0},
                   toggle: 1'b0, hold: 0, exp: -11};
        tab[1] = '{bias: 0, len: 1, a: '{-256, 0, 0, 0}, b: '{-256, 0, 0, 0},
                   toggle: 1'b0, hold: 0, exp: -65536};
        tab[2] = '{bias: 65535, len: 1, a: '{1, 0, 0, 0}, b: '{1, 0, 0, 0},
                   toggle: 1'b0, hold: 0, exp: -65536};
        tab[3] = '{bias: -5, len: 0, a: '{0, 0, 0, 0}, b: '{0, 0, 0, 0},
                   toggle: 1'b0, hold: 0, exp: -5};
        tab[4] = '{bias: 0, len: 4, a: '{1, 3, -5, 7}, b: '{2, 4, 6, 8},
                   toggle: 1'b1, hold: 0, exp: 40};

        #12;
        chk("reset busy", int'(busy), 0);
        chk("reset in_ready", int'(in_ready), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                pa[k] = tab[i].a[k];
                pb[k] = tab[i].b[k];
            end
            run_job(tab[i].bias, tab[i].len, tab[i].toggle, tab[i].hold, -1,
                    tab[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure: result held five cycles while start pulses are ignored.
        pa[0] = 2;  pb[0] = 3;
        pa[1] = -4; pb[1] = 5;
        pa[2] = 7;  pb[2] = -1;
        run_job(10, 3, 1'b0, 5, -1, -11, "hold");

        // Reset during RUN, then a fresh job.
        for (int k = 0; k < 5; k++) begin
            pa[k] = 100;
            pb[k] = 100;
        end
        run_job(7, 5, 1'b0, 0, 2, 0, "abort");
        pa[0] = 3;
        pb[0] = 3;
        run_job(1, 1, 1'b0, 0, -1, 10, "fresh");

        // Length clamp: NMAX+1 requested, only NMAX terms consumed.
        for (int k = 0; k < 80; k++) begin
            pa[k] = 1;
            pb[k] = 1;
        end
        run_job(0, NMAX + 1, 1'b0, 0, -1, NMAX, "clamp");

        for (int r = 0; r < 25; r++) begin
            int l;
            int b;
            l = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 8))
                                            : int'($urandom_range(0, NMAX + 3));
            for (int k = 0; k < 80; k++) begin
                pa[k] = int'($urandom_range(0, 511)) - 256;
                pb[k] = int'($urandom_range(0, 511)) - 256;
            end
            b = int'($urandom_range(0, 131071)) - 65536;
            run_job(b, l, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1,
                    model(b, (l > NMAX) ? NMAX : l), $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
